// File: rtl/aqua_dispense_ctrl.sv
// Bottle dispenser controller: queues vend/change requests, runs the motor,
// waits for the chute sensor and ejects change coins one pulse at a time.
module aqua_dispense_ctrl #(
  parameter int MOTOR_CYC   = 8,
  parameter int TIMEOUT_CYC = 64,
  parameter int STOCK_INIT  = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vend_req,
  input  logic [1:0] chg_req,
  input  logic       refill,
  input  logic       bottle_sense,
  output logic       motor_on,
  output logic       coin_eject,
  output logic [7:0] stock,
  output logic       sold_out,
  output logic       busy,
  output logic       q_full,
  output logic       q_ovf,
  output logic       fault
);

  typedef enum logic [2:0] {IDLE, MOTOR, WAIT_SENSE, COIN_HI, COIN_LO, FAULT} state_t;

  typedef struct packed {
    logic       vend;
    logic [2:0] coins;
  } entry_t;

  state_t      state, state_n;
  logic [15:0] tmr, tmr_n;
  logic [2:0]  coins_left, coins_n;
  logic        sensed, sensed_n;
  logic        dec;

  // Requests are captured in a register first so nothing downstream sees
  // the raw inputs combinationally.
  logic   req_v;
  entry_t req_e;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_v <= 1'b0;
      req_e <= '0;
    end else begin
      req_v      <= vend_req | (chg_req == 2'b01) | (chg_req == 2'b10);
      req_e.vend <= vend_req;
      req_e.coins <= (chg_req == 2'b11) ? 3'd0 : {1'b0, chg_req};
    end
  end

  entry_t     mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic       push, pop;
  entry_t     head;

  assign head = mem[rd_ptr];
  assign pop  = (state == IDLE) && (count != 3'd0);
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push = req_v && ((count != 3'd4) || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_e;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
      q_ovf  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      q_ovf <= req_v && !push;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tmr        <= '0;
      coins_left <= 3'd0;
      sensed     <= 1'b0;
    end else begin
      state      <= state_n;
      tmr        <= tmr_n;
      coins_left <= coins_n;
      sensed     <= sensed_n;
    end
  end

  always_comb begin
    state_n  = state;
    tmr_n    = '0;
    coins_n  = coins_left;
    sensed_n = sensed;
    dec      = 1'b0;
    case (state)
      IDLE: begin
        sensed_n = 1'b0;
        if (pop) begin
          // Sold out: refund the 10 rs price as two extra coins.
          coins_n = (head.vend && stock == 8'd0) ? head.coins + 3'd2 : head.coins;
          if (head.vend && stock != 8'd0) begin
            state_n = MOTOR;
            dec     = 1'b1;
          end else if (coins_n != 3'd0) begin
            state_n = COIN_HI;
          end
        end
      end
      MOTOR: begin
        tmr_n = tmr + 16'd1;
        if (bottle_sense) sensed_n = 1'b1;
        if (tmr == 16'(MOTOR_CYC - 1)) begin
          tmr_n = '0;
          if (sensed || bottle_sense)
            state_n = (coins_left != 3'd0) ? COIN_HI : IDLE;
          else
            state_n = WAIT_SENSE;
        end
      end
      WAIT_SENSE: begin
        tmr_n = tmr + 16'd1;
        if (bottle_sense) begin
          tmr_n   = '0;
          state_n = (coins_left != 3'd0) ? COIN_HI : IDLE;
        end else if (tmr == 16'(TIMEOUT_CYC - 1)) begin
          tmr_n   = '0;
          state_n = FAULT;
        end
      end
      COIN_HI: begin
        coins_n = coins_left - 3'd1;
        state_n = COIN_LO;
      end
      COIN_LO: state_n = (coins_left != 3'd0) ? COIN_HI : IDLE;
      FAULT:   state_n = FAULT;
      default: state_n = IDLE;
    endcase
  end

  // Refill takes priority; dec is only raised with stock nonzero, so no wrap.
  always_ff @(posedge clk) begin
    if (rst || refill) stock <= 8'(STOCK_INIT);
    else if (dec)      stock <= stock - 8'd1;
  end

  assign motor_on   = (state == MOTOR);
  assign coin_eject = (state == COIN_HI);
  assign fault      = (state == FAULT);
  assign sold_out   = (stock == 8'd0);
  assign busy       = (state != IDLE) || (count != 3'd0);
  assign q_full     = (count == 3'd4);

endmodule

// File: tb/tb_aqua_dispense_ctrl.sv
// Bench for aqua_dispense_ctrl: table of single-request services plus
// directed sequences, with a scoreboard of expected motor/coin events.
module tb_aqua_dispense_ctrl;

  localparam int MC = 8;
  localparam int TO = 64;
  localparam int SI = 20;
  localparam int EV_MOTOR = 0;
  localparam int EV_COIN  = 1;

  logic       clk = 1'b0;
  logic       rst, vend_req, refill, bottle_sense;
  logic [1:0] chg_req;
  logic       motor_on, coin_eject, sold_out, busy, q_full, q_ovf, fault;
  logic [7:0] stock;

  aqua_dispense_ctrl #(.MOTOR_CYC(MC), .TIMEOUT_CYC(TO), .STOCK_INIT(SI)) dut (
    .clk(clk), .rst(rst), .vend_req(vend_req), .chg_req(chg_req),
    .refill(refill), .bottle_sense(bottle_sense), .motor_on(motor_on),
    .coin_eject(coin_eject), .stock(stock), .sold_out(sold_out),
    .busy(busy), .q_full(q_full), .q_ovf(q_ovf), .fault(fault)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int sb[$];
  int motor_cnt = 0, coin_cnt = 0, ovf_cnt = 0;
  bit sense_en = 1'b1;
  bit mp = 1'b0, cp = 1'b0, sp = 1'b0;
  int ml = 0, cl = 0;

  typedef struct {
    logic       v;
    logic [1:0] c;
    int         m;
    int         coins;
    int         ds;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic sb_pop(input string nm, input int ev);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_%s: got unexpected pulse expected none queued", nm);
    end else begin
      chk({"sb_", nm}, sb.pop_front(), ev);
    end
  endtask

  task automatic expect_svc(input bit m, input int coins);
    if (m) sb.push_back(EV_MOTOR);
    for (int i = 0; i < coins; i++) sb.push_back(EV_COIN);
  endtask

  task automatic req(input logic v, input logic [1:0] c);
    @(negedge clk); vend_req = v; chg_req = c;
    @(negedge clk); vend_req = 1'b0; chg_req = 2'b00;
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (3) @(negedge clk);
    while (busy && n < 400) begin @(negedge clk); n++; end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic wait_sig_motor(input logic lvl);
    int n = 0;
    while (motor_on !== lvl && n < 100) begin @(negedge clk); n++; end
    chk("motor_wait", motor_on, lvl);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: pops the scoreboard on each motor/coin rising edge, checks widths.
  initial begin
    forever begin
      @(negedge clk);
      if (motor_on === 1'b1 && !mp) begin motor_cnt++; sb_pop("motor", EV_MOTOR); end
      if (motor_on === 1'b1) ml = mp ? ml + 1 : 1;
      else if (mp) chk("motor_len", ml, MC);
      if (coin_eject === 1'b1 && !cp) begin coin_cnt++; sb_pop("coin", EV_COIN); end
      if (coin_eject === 1'b1) cl = cp ? cl + 1 : 1;
      else if (cp) chk("coin_len", cl, 1);
      if (q_ovf === 1'b1) ovf_cnt++;
      mp = (motor_on === 1'b1);
      cp = (coin_eject === 1'b1);
    end
  end

  // Chute sensor model: one pulse two cycles into each motor run.
  initial begin
    bottle_sense = 1'b0;
    forever begin
      @(negedge clk);
      if (sense_en && motor_on === 1'b1 && !sp) begin
        @(negedge clk); @(negedge clk);
        bottle_sense = 1'b1;
        @(negedge clk);
        bottle_sense = 1'b0;
      end
      sp = (motor_on === 1'b1);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int m0, c0, s0, o0, n;
    logic [1:0] lst [5];
    tbl[0] = '{1'b1, 2'b00, 1, 0, 1};
    tbl[1] = '{1'b1, 2'b01, 1, 1, 1};
    tbl[2] = '{1'b1, 2'b10, 1, 2, 1};
    tbl[3] = '{1'b1, 2'b11, 1, 0, 1};
    tbl[4] = '{1'b0, 2'b01, 0, 1, 0};
    tbl[5] = '{1'b0, 2'b10, 0, 2, 0};
    tbl[6] = '{1'b0, 2'b11, 0, 0, 0};
    tbl[7] = '{1'b0, 2'b00, 0, 0, 0};
    lst[0] = 2'b00; lst[1] = 2'b01; lst[2] = 2'b10; lst[3] = 2'b00; lst[4] = 2'b01;

    rst = 1'b1; vend_req = 1'b0; chg_req = 2'b00; refill = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_motor", motor_on, 0);
    chk("rst_coin", coin_eject, 0);
    chk("rst_fault", fault, 0);
    chk("rst_qovf", q_ovf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_qfull", q_full, 0);
    chk("rst_stock", stock, SI);
    chk("rst_soldout", sold_out, 0);
    rst = 1'b0;

    // Vend with one coin change; motor visible two edges after sampling.
    m0 = motor_cnt; c0 = coin_cnt;
    expect_svc(1, 1);
    req(1'b1, 2'b01);
    chk("lat_k0", motor_on, 0);
    @(negedge clk); chk("lat_k1", motor_on, 0);
    @(negedge clk); chk("lat_k2", motor_on, 1);
    chk("s1_stock", stock, SI - 1);
    wait_idle();
    chk("s1_motors", motor_cnt - m0, 1);
    chk("s1_coins", coin_cnt - c0, 1);
    chk("s1_sb_empty", sb.size(), 0);

    for (int i = 0; i < 8; i++) begin
      m0 = motor_cnt; c0 = coin_cnt; s0 = int'(stock);
      expect_svc(tbl[i].m != 0, tbl[i].coins);
      req(tbl[i].v, tbl[i].c);
      wait_idle();
      chk($sformatf("tbl%0d_motors", i), motor_cnt - m0, tbl[i].m);
      chk($sformatf("tbl%0d_coins", i), coin_cnt - c0, tbl[i].coins);
      chk($sformatf("tbl%0d_stock", i), stock, s0 - tbl[i].ds);
    end
    chk("tbl_sb_empty", sb.size(), 0);

    // Drain stock, then sold-out refund of 2 + 2 coins.
    do_reset();
    for (int i = 0; i < SI; i++) begin
      expect_svc(1, 0);
      req(1'b1, 2'b00);
      wait_idle();
    end
    chk("s2_stock0", stock, 0);
    chk("s2_soldout", sold_out, 1);
    m0 = motor_cnt;
    expect_svc(0, 4);
    req(1'b1, 2'b10);
    n = 0;
    while (coin_eject !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("s2_coin_hi%0d", i), coin_eject, 1);
      @(negedge clk);
      chk($sformatf("s2_coin_lo%0d", i), coin_eject, 0);
      @(negedge clk);
    end
    wait_idle();
    chk("s2_no_motor", motor_cnt - m0, 0);
    chk("s2_stock_still0", stock, 0);
    @(negedge clk); refill = 1'b1;
    @(negedge clk); refill = 1'b0;
    chk("s2_refill_stock", stock, SI);
    chk("s2_refill_soldout", sold_out, 0);
    chk("s2_sb_empty", sb.size(), 0);

    // Missing sensor: fault after the timeout, queue still fills and overflows.
    do_reset();
    sense_en = 1'b0;
    expect_svc(1, 0);
    req(1'b1, 2'b01);
    wait_sig_motor(1'b1);
    wait_sig_motor(1'b0);
    chk("s3_fault_at_end", fault, 0);
    repeat (TO - 1) @(negedge clk);
    chk("s3_fault_early", fault, 0);
    @(negedge clk);
    chk("s3_fault_set", fault, 1);
    chk("s3_motor_off", motor_on, 0);
    chk("s3_stock", stock, SI - 1);
    o0 = ovf_cnt;
    @(negedge clk); vend_req = 1'b1;
    repeat (5) @(negedge clk);
    vend_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("s3_qfull", q_full, 1);
    chk("s3_ovf_once", ovf_cnt - o0, 1);
    chk("s3_fault_sticky", fault, 1);
    chk("s3_sb_empty", sb.size(), 0);
    sense_en = 1'b1;

    // Burst of 5 while busy: 4 queued and served in order, 1 dropped.
    do_reset();
    o0 = ovf_cnt;
    expect_svc(1, 0);
    req(1'b1, 2'b00);
    wait_sig_motor(1'b1);
    for (int i = 0; i < 4; i++) expect_svc(1, (lst[i] == 2'b11) ? 0 : int'(lst[i]));
    for (int i = 0; i < 5; i++) begin
      vend_req = 1'b1; chg_req = lst[i];
      @(negedge clk);
    end
    vend_req = 1'b0; chg_req = 2'b00;
    chk("s4_qfull", q_full, 1);
    wait_idle();
    chk("s4_ovf_once", ovf_cnt - o0, 1);
    chk("s4_stock", stock, SI - 5);
    chk("s4_sb_empty", sb.size(), 0);

    // Refill on the same edge as the MOTOR-entry decrement.
    do_reset();
    expect_svc(1, 0);
    req(1'b1, 2'b00);
    @(negedge clk); refill = 1'b1;
    @(negedge clk); refill = 1'b0;
    chk("s5_motor", motor_on, 1);
    chk("s5_stock_refill_wins", stock, SI);
    wait_idle();
    chk("s5_stock_after", stock, SI);
    chk("s5_sb_empty", sb.size(), 0);

    // Reset in COIN_HI with two coins pending: second coin never appears.
    do_reset();
    expect_svc(1, 1);
    req(1'b1, 2'b10);
    n = 0;
    while (coin_eject !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    chk("s6_in_coin", coin_eject, 1);
    chk("s6_stock_pre", stock, SI - 1);
    rst = 1'b1;
    @(negedge clk);
    chk("s6_coin_off", coin_eject, 0);
    chk("s6_busy_off", busy, 0);
    chk("s6_stock_rst", stock, SI);
    chk("s6_motor_off", motor_on, 0);
    rst = 1'b0;
    c0 = coin_cnt; m0 = motor_cnt;
    repeat (20) @(negedge clk);
    chk("s6_no_more_coins", coin_cnt - c0, 0);
    chk("s6_no_more_motor", motor_cnt - m0, 0);
    chk("s6_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
